pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 46 ++++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if -- bundle of the fetch/issue/next-PC signals around the
// program-counter sequencer.
//
//   imem_addr, imem_req      : fetch request and address towards instr memory
//   imem_ready, imem_data    : memory response (opcode in imem_data[18:13])
//   instr_out, instr_valid   : registered instruction towards decoder/datapath
//   instr_accept             : datapath completes the current instruction
//   sel_PCSrc_*              : one-hot next-PC source from the decoder
//   jump_offset, jump_const  : signed branch offset / absolute jump target
//   cond_taken               : branch condition, sampled with instr_accept
//   pc, seq_error            : current PC and sticky illegal-select flag
//
// Modport master is the sequencer itself; slave is its environment.
// ---------------------------------------------------------------------------
interface pc_sequencer_if;
  logic [11:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [18:0] imem_data;
  logic [18:0] instr_out;
  logic        instr_valid;
  logic        instr_accept;
  logic        sel_PCSrc_plus1;
  logic        sel_PCSrc_offset;
  logic        sel_PCSrc_const;
  logic [7:0]  jump_offset;
  logic [11:0] jump_const;
  logic        cond_taken;
  logic [11:0] pc;
  logic        seq_error;

  modport master (
    output imem_addr, imem_req, instr_out, instr_valid, pc, seq_error,
    input  imem_ready, imem_data, instr_accept,
           sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const,
           jump_offset, jump_const, cond_taken
  );

  modport slave (
    input  imem_addr, imem_req, instr_out, instr_valid, pc, seq_error,
    output imem_ready, imem_data, instr_accept,
           sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const,
           jump_offset, jump_const, cond_taken
  );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer -- fetch/issue sequencer owning the 12-bit program counter.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset (FETCH, pc=0, instr_out=0)
//   bus  : pc_sequencer_if.master (fetch handshake, issue handshake,
//          next-PC select inputs, pc and seq_error outputs)
//
// Operation: FETCH requests imem[pc]; on imem_ready the word is latched and
// the block moves to ISSUE, holding instr_out/pc until instr_accept. On
// accept the pc is reloaded from the one-hot select (plus1, conditional
// offset, absolute const) and the block returns to FETCH.
//
// Configuration macro PC_SEQ_ERROR_HALT_EN:
//   defined   - an illegal select (not one-hot) sets seq_error, keeps pc and
//               parks the block in HALT until reset.
//   undefined - an illegal select behaves as plus1; seq_error is tied to 0.
// ---------------------------------------------------------------------------
module pc_sequencer (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [11:0] r_pc;
  logic [18:0] r_instr;

  logic [2:0]  w_sel;
  logic [11:0] w_pcPlus1;
  logic [11:0] w_offsetExt;
  logic [11:0] w_pcBranch;
  logic [11:0] w_pcNext;

  assign w_sel       = {bus.sel_PCSrc_const, bus.sel_PCSrc_offset, bus.sel_PCSrc_plus1};
  assign w_pcPlus1   = r_pc + 12'd1;
  assign w_offsetExt = {{4{bus.jump_offset[7]}}, bus.jump_offset};
  // 12-bit adders wrap naturally, giving modulo-4096 pc arithmetic.
  assign w_pcBranch  = w_pcPlus1 + w_offsetExt;

  // Anything that is not exactly "offset" or "const" falls back to pc+1,
  // which is also the treatment of illegal selects when not halting on them.
  always_comb begin
    w_pcNext = w_pcPlus1;
    if (w_sel == 3'b010 && bus.cond_taken) begin
      w_pcNext = w_pcBranch;
    end else if (w_sel == 3'b100) begin
      w_pcNext = bus.jump_const;
    end
  end

`ifdef PC_SEQ_ERROR_HALT_EN
  logic r_seqError;
  logic w_selLegal;

  assign w_selLegal = (w_sel == 3'b001) || (w_sel == 3'b010) || (w_sel == 3'b100);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= 12'h000;
      r_instr <= 19'h00000;
`ifdef PC_SEQ_ERROR_HALT_EN
      r_seqError <= 1'b0;
`endif
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.imem_ready) begin
            r_instr <= bus.imem_data;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.instr_accept) begin
`ifdef PC_SEQ_ERROR_HALT_EN
            if (w_selLegal) begin
              r_pc    <= w_pcNext;
              r_state <= FETCH;
            end else begin
              r_seqError <= 1'b1;
              r_state    <= HALT;
            end
`else
            r_pc    <= w_pcNext;
            r_state <= FETCH;
`endif
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Handshake outputs decode the state register; they are masked by rst so
  // that both are low during the reset cycle and imem_req rises in the very
  // first cycle after rst drops.
  assign bus.imem_req    = (r_state == FETCH) && !rst;
  assign bus.instr_valid = (r_state == ISSUE) && !rst;
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.instr_out   = r_instr;

`ifdef PC_SEQ_ERROR_HALT_EN
  assign bus.seq_error = r_seqError;
`else
  assign bus.seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer -- self-checking bench for pc_sequencer.
//
// A transaction-level model (is an instruction held? is the block halted?
// what is the pc?) is advanced on every rising edge from the applied inputs;
// a negedge process compares all DUT outputs against it every cycle.
// Directed scenarios pin the model with literal expectations, then a long
// randomized run (random resets, stray ready/accept, illegal selects) follows.
// Honours PC_SEQ_ERROR_HALT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit          modelValid = 1'b0;
  bit          mHolding;
  bit          mHalted;
  bit          mErr;
  logic [11:0] mPc;
  logic [18:0] mInstr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next pc from the architectural rules, using integer arithmetic.
  function automatic logic [11:0] modelNextPc(input logic [11:0] cur, input logic [2:0] sel,
                                              input logic [7:0] off, input logic [11:0] cn,
                                              input bit tk);
    int t;
    if (sel == 3'b100) return cn;
    t = int'(cur) + 1;
    if (sel == 3'b010 && tk) t = t + int'($signed(off));
    t = ((t % 4096) + 4096) % 4096;
    return t[11:0];
  endfunction

  always @(posedge clk) begin
    logic [2:0] sel;
    sel = {bus.sel_PCSrc_const, bus.sel_PCSrc_offset, bus.sel_PCSrc_plus1};
    if (rst) begin
      modelValid = 1'b1;
      mHolding   = 1'b0;
      mHalted    = 1'b0;
      mErr       = 1'b0;
      mPc        = 12'h000;
      mInstr     = 19'h00000;
    end else if (modelValid && !mHalted) begin
      if (!mHolding) begin
        if (bus.imem_ready) begin
          mInstr   = bus.imem_data;
          mHolding = 1'b1;
        end
      end else if (bus.instr_accept) begin
        mHolding = 1'b0;
        if ($countones(sel) != 1) begin
`ifdef PC_SEQ_ERROR_HALT_EN
          mErr    = 1'b1;
          mHalted = 1'b1;
`else
          mPc = modelNextPc(mPc, 3'b001, 8'h00, 12'h000, 1'b0);
`endif
        end else begin
          mPc = modelNextPc(mPc, sel, bus.jump_offset, bus.jump_const, bus.cond_taken);
        end
      end
    end
  end

  always @(negedge clk) begin
    bit expReq;
    if (modelValid) begin
      expReq = !rst && !mHolding && !mHalted;
      checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
      checkOutput("instr_valid", 32'(bus.instr_valid), 32'(!rst && mHolding));
      checkOutput("pc", 32'(bus.pc), 32'(mPc));
      if (expReq) checkOutput("imem_addr", 32'(bus.imem_addr), 32'(mPc));
      checkOutput("instr_out", 32'(bus.instr_out), 32'(mInstr));
      checkOutput("seq_error", 32'(bus.seq_error), 32'(mErr));
    end
  end

  // Drive all inputs for one rising edge; returns 1 time unit after it.
  task automatic applyStimulus(input bit r, input bit rdy, input logic [18:0] d, input bit acc,
                               input logic [2:0] sel, input logic [7:0] off,
                               input logic [11:0] cn, input bit tk);
    rst                  = r;
    bus.imem_ready       = rdy;
    bus.imem_data        = d;
    bus.instr_accept     = acc;
    bus.sel_PCSrc_plus1  = sel[0];
    bus.sel_PCSrc_offset = sel[1];
    bus.sel_PCSrc_const  = sel[2];
    bus.jump_offset      = off;
    bus.jump_const       = cn;
    bus.cond_taken       = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 19'h0, 1'b0, 3'b000, 8'h00, 12'h000, 1'b0);
  endtask

  // One full instruction from FETCH: fetch, hold in ISSUE, accept.
  // During the hold, imem_ready is asserted with junk data to show it is ignored.
  task automatic doInstr(input logic [18:0] d, input logic [2:0] sel, input logic [7:0] off,
                         input logic [11:0] cn, input bit tk, input int holdCycles);
    logic [11:0] pcBefore;
    pcBefore = bus.pc;
    applyStimulus(1'b0, 1'b1, d, 1'b0, 3'b000, 8'h00, 12'h000, 1'b0);
    checkOutput("fetch_instr_out", 32'(bus.instr_out), 32'(d));
    checkOutput("fetch_instr_valid", 32'(bus.instr_valid), 32'd1);
    for (int i = 0; i < holdCycles; i++) begin
      applyStimulus(1'b0, 1'b1, 19'h7FFFF, 1'b0, 3'b000, 8'h00, 12'h000, 1'b0);
      checkOutput("hold_imem_req", 32'(bus.imem_req), 32'd0);
      checkOutput("hold_instr_out", 32'(bus.instr_out), 32'(d));
      checkOutput("hold_pc", 32'(bus.pc), 32'(pcBefore));
    end
    applyStimulus(1'b0, 1'b0, 19'h0, 1'b1, sel, off, cn, tk);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 19'h0, 1'b0, 3'b000, 8'h00, 12'h000, 1'b0);
    applyStimulus(1'b1, 1'b1, 19'h12345, 1'b1, 3'b001, 8'h00, 12'h000, 1'b0);
    checkOutput("rst_pc", 32'(bus.pc), 32'h000);
    checkOutput("rst_instr_out", 32'(bus.instr_out), 32'h00000);
    checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rst_seq_error", 32'(bus.seq_error), 32'd0);

    // Stray accept in FETCH is ignored.
    applyStimulus(1'b0, 1'b0, 19'h0, 1'b1, 3'b100, 8'h00, 12'hABC, 1'b0);
    checkOutput("first_imem_req", 32'(bus.imem_req), 32'd1);
    checkOutput("first_imem_addr", 32'(bus.imem_addr), 32'h000);

    doInstr(19'h0A5A5, 3'b001, 8'h00, 12'h000, 1'b0, 1);
    checkOutput("plus1_pc", 32'(bus.pc), 32'h001);
    checkOutput("plus1_imem_addr", 32'(bus.imem_addr), 32'h001);

    doInstr(19'h00001, 3'b100, 8'h00, 12'h010, 1'b0, 0);
    doInstr(19'h00002, 3'b010, 8'hFC, 12'h000, 1'b1, 0);
    checkOutput("offset_taken_pc", 32'(bus.pc), 32'h00D);

    doInstr(19'h00003, 3'b100, 8'h00, 12'h010, 1'b0, 0);
    doInstr(19'h00004, 3'b010, 8'hFC, 12'h000, 1'b0, 0);
    checkOutput("offset_not_taken_pc", 32'(bus.pc), 32'h011);

    doInstr(19'h00005, 3'b100, 8'h00, 12'h3C0, 1'b0, 2);
    checkOutput("const_pc", 32'(bus.pc), 32'h3C0);
    checkOutput("const_imem_addr", 32'(bus.imem_addr), 32'h3C0);

    doInstr(19'h00006, 3'b100, 8'h00, 12'hFFF, 1'b0, 0);
    doInstr(19'h00007, 3'b001, 8'h00, 12'h000, 1'b0, 0);
    checkOutput("wrap_plus1_pc", 32'(bus.pc), 32'h000);

    doInstr(19'h00008, 3'b100, 8'h00, 12'hFFE, 1'b0, 0);
    doInstr(19'h00009, 3'b010, 8'h05, 12'h000, 1'b1, 0);
    checkOutput("wrap_offset_pc", 32'(bus.pc), 32'h004);

    doInstr(19'h7E001, 3'b001, 8'h00, 12'h000, 1'b0, 10);
    checkOutput("long_hold_pc", 32'(bus.pc), 32'h005);

    doInstr(19'h0000A, 3'b100, 8'h00, 12'h123, 1'b0, 0);
    doInstr(19'h0000B, 3'b011, 8'h00, 12'h000, 1'b0, 0);
`ifdef PC_SEQ_ERROR_HALT_EN
    checkOutput("illegal_pc", 32'(bus.pc), 32'h123);
    checkOutput("illegal_seq_error", 32'(bus.seq_error), 32'd1);
    repeat (3) applyStimulus(1'b0, 1'b1, 19'h1, 1'b1, 3'b001, 8'h00, 12'h000, 1'b0);
    checkOutput("halt_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("halt_instr_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("halt_pc", 32'(bus.pc), 32'h123);
    applyStimulus(1'b1, 1'b0, 19'h0, 1'b0, 3'b000, 8'h00, 12'h000, 1'b0);
    checkOutput("halt_rst_pc", 32'(bus.pc), 32'h000);
    checkOutput("halt_rst_seq_error", 32'(bus.seq_error), 32'd0);
`else
    checkOutput("illegal_pc", 32'(bus.pc), 32'h124);
    checkOutput("illegal_seq_error", 32'(bus.seq_error), 32'd0);
`endif

    // Reset in the middle of an issue with a coincident accept.
    idle(1);
    applyStimulus(1'b0, 1'b1, 19'h2AAAA, 1'b0, 3'b000, 8'h00, 12'h000, 1'b0);
    applyStimulus(1'b1, 1'b0, 19'h0, 1'b1, 3'b100, 8'h00, 12'h777, 1'b0);
    checkOutput("mid_issue_rst_pc", 32'(bus.pc), 32'h000);
    checkOutput("mid_issue_rst_instr", 32'(bus.instr_out), 32'h00000);
    idle(1);

    for (int i = 0; i < 4000; i++) begin
      logic [2:0] s;
      if ($urandom_range(3, 0) == 0) s = 3'($urandom_range(7, 0));
      else s = 3'b001 << $urandom_range(2, 0);
      applyStimulus($urandom_range(59, 0) == 0, $urandom_range(2, 0) == 0, 19'($urandom),
                    $urandom_range(2, 0) == 0, s, 8'($urandom), 12'($urandom),
                    1'($urandom_range(1, 0)));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
